spart_rx_fifo: RTL
==================

# spart_rx_fifo

Parametrised receive path for the next-generation SPART. It oversamples `rxd`, frames characters with configurable data width and parity, and buffers them in a show-ahead FIFO. Error flags are sticky. The block sits between the pin-side `rxd` and the bus-side register logic, and replaces the single-byte, fixed-format receive buffer used today.

## Interface
- `DATA_W`, 8, data bits per character, legal range 5..9
- `FIFO_DEPTH`, 8, receive FIFO entries; must be a power of 2, ≥2
- `PARITY`, 0, parity mode: 0 none, 1 even, 2 odd
- `OVS`, 16, oversample ticks per bit; even, ≥4
- `clk  in  1` system clock
- `rst_n  in  1` reset, asynchronous assert, active-low
- `divisor  in  16` clk cycles per oversample tick, minus 1
- `rxd  in  1` serial input, asynchronous, idle high
- `rd_en  in  1` pop FIFO head
- `err_clr  in  1` clear all sticky error flags
- `rd_data  out  DATA_W` FIFO head (show-ahead)
- `rda  out  1` FIFO non-empty
- `fifo_count  out  $clog2(FIFO_DEPTH)+1` occupancy
- `frame_err  out  1` sticky: stop bit sampled 0
- `parity_err  out  1` sticky: parity mismatch
- `overrun  out  1` sticky: character dropped because FIFO was full

## Operation
- **Input synchronisation:** `rxd` passes through a 2-flop synchroniser, reset to 1. All logic uses the synchronised value `rxs`.
- **Tick counter:** down-counter loaded with `divisor`. It emits one `tick` when it reaches 0, then reloads. `divisor`=0 gives a tick every cycle.
- **FSM states:** IDLE, START, DATA, PAR, STOP, BRK.
  - IDLE: a falling edge on `rxs` reloads the tick counter, clears the sample counter `sc`, and enters START.
  - START: on `tick` with `sc`=OVS/2-1, sample `rxs`. If it is 1 (glitch), go to IDLE and push nothing. Otherwise clear `sc` and go to DATA.
  - DATA: sample on every OVS-th tick. Bits shift in LSB first. After DATA_W bits, go to PAR if PARITY≠0, else STOP.
  - PAR: sample one bit. Even mode requires XOR(data, parity bit)=0; odd mode requires 1. Record any mismatch.
  - STOP: sample one bit.
    - Sample 0: set `frame_err`, discard the character, enter BRK.
    - Sample 1 with a parity mismatch: set `parity_err`, discard the character.
    - Sample 1, parity clean: push the character.
    - In both stop=1 cases, return to IDLE.
  - BRK: wait until `rxs`=1, then go to IDLE, so a break produces exactly one error.
- **FIFO:** circular buffer with pointers one bit wider than the address.
  - Push when full: drop the character and set `overrun`. Existing contents are unchanged.
  - `rd_en` with `rda`=0 is ignored.
  - Push and pop in the same cycle: both happen and `fifo_count` is unchanged. This holds when full too: the pop frees the slot and `overrun` is not set.
- **Sticky flags:** `err_clr` clears all three. If a set event and `err_clr` occur in the same cycle, set wins.
- **Divisor changes:** `divisor` may change at any time. The new value takes effect at the next reload.

## Timing
- **Reset values:** `rda`=0, `fifo_count`=0, `rd_data`=0, all error flags=0, FSM=IDLE, synchroniser=1.
- **Reset mid-frame:** the partial character is lost. The FIFO is emptied.
- **Input latency:** 2 clk from the `rxd` pin to `rxs`.
- **Sample points:** bit n (start = 0) is sampled on the tick numbered OVS/2 + n·OVS after the falling edge is detected.
- **Push latency:** the push is registered in the cycle after the stop-bit sample. `rda` and `rd_data` are valid on the following clk edge.
- **Pop:** `rd_en` at edge k means `rd_data` shows the next entry after edge k, and `fifo_count` decrements at k.
- **Minimum idle:** one full stop bit (OVS ticks from the stop-sample to the next start) is not required. The next falling edge may occur at the half-bit point after the stop sample.

## Structure
- **Package `spart_pkg`:** `parity_e` (NONE, EVEN, ODD), `rx_state_e`, and the `DIV_W`=16 constant. It is shared with the future `spart_tx_fifo`.
- **Sub-module `spart_sync_fifo`:** parameters `W` and `DEPTH`; show-ahead read with count output. It will be reused on the transmit side. The FSM, tick counter and synchroniser stay in the top module.

## Test plan
- **Single character:** `divisor`=0, OVS=16, 8N1; send 0xA6 at 16 clk/bit → `rda`=1, `rd_data`=0xA6, `fifo_count`=1, no flags. `rd_en` pulse → `rda`=0.
- **Start glitch:** low pulse of 4 clk on `rxd` → no push, FSM back in IDLE, no flags.
- **Framing error / break:** send 0x59 with stop bit 0, then hold low for 40 bit times → `frame_err`=1 once, `fifo_count`=0. After `rxd` returns high, 0x3C is received correctly.
- **Parity:** PARITY=1 (even), DATA_W=7; send 0x41 with parity bit 1 → `parity_err`=1, no push. Same character with parity bit 0 → pushed. `err_clr` → flag clears.
- **Overrun and wrap:** FIFO_DEPTH=8; send 0x00..0x08 without reading → `overrun`=1, `fifo_count`=8, head 0x00. Read all → 0x00..0x07 in order. Then send and read 12 more to exercise pointer wrap.
- **Concurrency and reset:** `rd_en` in the same cycle as a push into a full FIFO → no overrun, count stays 8. Assert `rst_n` low mid-character → all outputs at reset values.

Source files
------------

// File: rtl/spart_pkg.sv
// Shared SPART definitions: parity modes, receive FSM states and divisor width.
// The transmit side uses this package as well.
package spart_pkg;

    localparam int DIV_W = 16;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        EVEN = 2'd1,
        ODD  = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP,
        BRK
    } rx_state_e;

endpackage

// File: rtl/spart_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count and a drop strobe for pushes into a full buffer.
// A pop in the same cycle as a push into a full FIFO frees the slot, so the push lands.
module spart_sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [W-1:0]             wdata_i,
    input  logic                     pop_i,
    output logic [W-1:0]             rdata_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     drop_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]   wptr_q, rptr_q;
    logic [W-1:0]  mem_q [DEPTH];
    logic          full, do_pop, do_push;

    assign empty_o = (wptr_q == rptr_q);
    assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full || do_pop);
    assign drop_o  = push_i && !do_push;
    assign count_o = wptr_q - rptr_q;
    assign rdata_o = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/spart_rx_fifo.sv
// SPART receiver: oversampling framer with optional parity, sticky error flags,
// and a show-ahead receive FIFO.
module spart_rx_fifo
    import spart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int PARITY     = 0,
    parameter int OVS        = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [DIV_W-1:0]                divisor,
    input  logic                            rxd,
    input  logic                            rd_en,
    input  logic                            err_clr,
    output logic [DATA_W-1:0]               rd_data,
    output logic                            rda,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
    output logic                            frame_err,
    output logic                            parity_err,
    output logic                            overrun
);

    localparam int      SCW   = $clog2(OVS);
    localparam int      BCW   = $clog2(DATA_W + 1);
    localparam parity_e PMODE = parity_e'(PARITY);

    logic              sync1_q, rxs_q, rxs_prev_q;
    logic              fall, tick;
    logic [DIV_W-1:0]  tcnt_q;
    rx_state_e         state_q;
    logic [SCW-1:0]    sc_q;
    logic [BCW-1:0]    bc_q;
    logic [DATA_W-1:0] shreg_q;
    logic              par_bad_q, push_q, fe_set_q, pe_set_q;
    logic              fifo_empty, fifo_drop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= 1'b1;
            rxs_q      <= 1'b1;
            rxs_prev_q <= 1'b1;
        end else begin
            sync1_q    <= rxd;
            rxs_q      <= sync1_q;
            rxs_prev_q <= rxs_q;
        end
    end

    assign fall = rxs_prev_q && !rxs_q;
    assign tick = (tcnt_q == '0);

    // The start edge realigns the tick phase so sample points are centred on the bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                        tcnt_q <= '0;
        else if (state_q == IDLE && fall)  tcnt_q <= divisor;
        else if (tick)                     tcnt_q <= divisor;
        else                               tcnt_q <= tcnt_q - DIV_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sc_q      <= '0;
            bc_q      <= '0;
            shreg_q   <= '0;
            par_bad_q <= 1'b0;
            push_q    <= 1'b0;
            fe_set_q  <= 1'b0;
            pe_set_q  <= 1'b0;
        end else begin
            push_q   <= 1'b0;
            fe_set_q <= 1'b0;
            pe_set_q <= 1'b0;
            case (state_q)
                IDLE: if (fall) begin
                    sc_q    <= '0;
                    state_q <= START;
                end
                START: if (tick) begin
                    if (sc_q == SCW'(OVS/2 - 1)) begin
                        sc_q <= '0;
                        bc_q <= '0;
                        state_q <= rxs_q ? IDLE : DATA;
                    end else begin
                        sc_q <= sc_q + 1'b1;
                    end
                end
                DATA: if (tick) begin
                    if (sc_q == SCW'(OVS - 1)) begin
                        sc_q    <= '0;
                        shreg_q <= {rxs_q, shreg_q[DATA_W-1:1]};
                        if (bc_q == BCW'(DATA_W - 1)) begin
                            par_bad_q <= 1'b0;
                            state_q   <= (PMODE != NONE) ? PAR : STOP;
                        end else begin
                            bc_q <= bc_q + 1'b1;
                        end
                    end else begin
                        sc_q <= sc_q + 1'b1;
                    end
                end
                PAR: if (tick) begin
                    if (sc_q == SCW'(OVS - 1)) begin
                        sc_q      <= '0;
                        par_bad_q <= ((^shreg_q) ^ rxs_q) != (PMODE == ODD);
                        state_q   <= STOP;
                    end else begin
                        sc_q <= sc_q + 1'b1;
                    end
                end
                STOP: if (tick) begin
                    if (sc_q == SCW'(OVS - 1)) begin
                        sc_q <= '0;
                        if (!rxs_q) begin
                            fe_set_q <= 1'b1;
                            state_q  <= BRK;
                        end else begin
                            pe_set_q <= par_bad_q;
                            push_q   <= !par_bad_q;
                            state_q  <= IDLE;
                        end
                    end else begin
                        sc_q <= sc_q + 1'b1;
                    end
                end
                BRK: if (rxs_q) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // shreg_q is stable until the next character's first data sample, so it feeds the FIFO directly.
    spart_sync_fifo #(
        .W     (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_q),
        .wdata_i (shreg_q),
        .pop_i   (rd_en),
        .rdata_o (rd_data),
        .empty_o (fifo_empty),
        .count_o (fifo_count),
        .drop_o  (fifo_drop)
    );

    assign rda = !fifo_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (fe_set_q)       frame_err  <= 1'b1;
            else if (err_clr)   frame_err  <= 1'b0;
            if (pe_set_q)       parity_err <= 1'b1;
            else if (err_clr)   parity_err <= 1'b0;
            if (fifo_drop)      overrun    <= 1'b1;
            else if (err_clr)   overrun    <= 1'b0;
        end
    end

endmodule
